// File: rtl/spi_master.sv
// Byte-wide SPI master, mode 0, run-time clock divisor.
// Define SPI_LSB_FIRST_EN to shift LSB first; the default build is MSB first.
module spi_master (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] din,
    input  logic [7:0] dvsr,
    input  logic       wr,
    output logic [7:0] dout,
    output logic       spi_clk,
    output logic       spi_mosi,
    input  logic       spi_miso,
    output logic       spi_done,
    output logic       spi_idle
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] P0   = 2'd1;
    localparam logic [1:0] P1   = 2'd2;

    logic [1:0] state;
    logic [7:0] cnt;
    logic [2:0] bit_cnt;
    logic [7:0] tx;
    logic [7:0] rx;
    logic [7:0] dvsr_q;

    logic       first_bit;
    logic [7:0] tx_shifted;
    logic [7:0] rx_shifted;

`ifdef SPI_LSB_FIRST_EN
    assign first_bit  = din[0];
    assign tx_shifted = {1'b0, tx[7:1]};
    assign rx_shifted = {spi_miso, rx[7:1]};
`else
    assign first_bit  = din[7];
    assign tx_shifted = {tx[6:0], 1'b0};
    assign rx_shifted = {rx[6:0], spi_miso};
`endif

    assign spi_idle = (state == IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= 8'd0;
            bit_cnt  <= 3'd0;
            tx       <= 8'd0;
            rx       <= 8'd0;
            dvsr_q   <= 8'd0;
            dout     <= 8'd0;
            spi_clk  <= 1'b0;
            spi_mosi <= 1'b0;
            spi_done <= 1'b0;
        end else begin
            spi_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (wr) begin
                        state    <= P0;
                        tx       <= din;
                        dvsr_q   <= dvsr;
                        cnt      <= 8'd0;
                        bit_cnt  <= 3'd0;
                        spi_clk  <= 1'b0;
                        spi_mosi <= first_bit;
                    end
                end
                P0: begin
                    if (cnt == dvsr_q) begin
                        cnt     <= 8'd0;
                        rx      <= rx_shifted;
                        spi_clk <= 1'b1;
                        state   <= P1;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                P1: begin
                    if (cnt == dvsr_q) begin
                        cnt     <= 8'd0;
                        spi_clk <= 1'b0;
                        if (bit_cnt == 3'd7) begin
                            dout     <= rx;
                            spi_done <= 1'b1;
                            state    <= IDLE;
                        end else begin
                            // mosi is the next bit of the shifted word, registered with the falling edge
                            tx       <= tx_shifted;
`ifdef SPI_LSB_FIRST_EN
                            spi_mosi <= tx_shifted[0];
`else
                            spi_mosi <= tx_shifted[7];
`endif
                            bit_cnt  <= bit_cnt + 3'd1;
                            state    <= P0;
                        end
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master.sv
// Randomised bench for spi_master against a cycle-index arithmetic model.
// Honours SPI_LSB_FIRST_EN the same way as the design.
module tb_spi_master;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] din;
    logic [7:0] dvsr;
    logic       wr;
    logic [7:0] dout;
    logic       spi_clk;
    logic       spi_mosi;
    logic       spi_miso;
    logic       spi_done;
    logic       spi_idle;

    int total = 0;
    int bad   = 0;

    spi_master dut (
        .clk      (clk),
        .rst      (rst),
        .din      (din),
        .dvsr     (dvsr),
        .wr       (wr),
        .dout     (dout),
        .spi_clk  (spi_clk),
        .spi_mosi (spi_mosi),
        .spi_miso (spi_miso),
        .spi_done (spi_done),
        .spi_idle (spi_idle)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // b-th bit on the wire of byte v
    function automatic logic wire_bit(input logic [7:0] v, input int b);
`ifdef SPI_LSB_FIRST_EN
        return v[b];
`else
        return v[7-b];
`endif
    endfunction

    // Called at a negedge with the DUT idle. k counts cycles after the start edge.
    task automatic run_xfer(input logic [7:0] d_in, input logic [7:0] dv, input logic [7:0] m,
                            input bit loop, input bit hold);
        int per;
        int t;
        int b;
        per  = int'(dv) + 1;
        t    = 16 * per;
        wr   = 1'b1;
        din  = d_in;
        dvsr = dv;
        spi_miso = 1'b0;
        @(posedge clk);
        for (int k = 0; k <= t; k++) begin
            @(negedge clk);
            if (k < t) begin
                b = k / (2 * per);
                check("idle_busy", spi_idle, 0);
                check("sclk", spi_clk, (k / per) % 2);
                check("mosi", spi_mosi, wire_bit(d_in, b));
                check("done_low", spi_done, 0);
                spi_miso = loop ? spi_mosi : wire_bit(m, b);
                wr   = 1'($urandom_range(0, 1));
                din  = 8'($urandom);
                dvsr = 8'($urandom);
            end else begin
                check("done_pulse", spi_done, 1);
                check("idle_done", spi_idle, 1);
                check("sclk_done", spi_clk, 0);
                check("dout", dout, loop ? d_in : m);
                if (!hold) wr = 1'b0;
            end
        end
    endtask

    initial begin
        rst = 1'b1; wr = 1'b1; din = 8'h5A; dvsr = 8'd0; spi_miso = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("rst_idle", spi_idle, 1);
            check("rst_sclk", spi_clk, 0);
            check("rst_mosi", spi_mosi, 0);
            check("rst_dout", dout, 8'h00);
            check("rst_done", spi_done, 0);
        end
        wr = 1'b0; rst = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check("post_rst_idle", spi_idle, 1);
        end

        run_xfer(8'hA5, 8'd7, 8'h00, 1'b0, 1'b0);
        run_xfer(8'h3C, 8'd3, 8'h00, 1'b1, 1'b0);
        run_xfer(8'hFF, 8'd0, 8'hFF, 1'b0, 1'b0);

        // back-to-back with wr held; the done cycle is the only idle gap
        for (int i = 0; i < 4; i++)
            run_xfer(8'($urandom), 8'd7, 8'($urandom), 1'b0, i != 3);

        for (int i = 0; i < 12; i++)
            run_xfer(8'($urandom), 8'($urandom_range(0, 5)), 8'($urandom),
                     1'($urandom_range(0, 1)), (i != 11) && ($urandom_range(0, 1) == 1));

        // abort during bit 4
        wr = 1'b1; din = 8'hC3; dvsr = 8'd3;
        @(posedge clk);
        wr = 1'b0;
        repeat (36) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort_idle", spi_idle, 1);
        check("abort_sclk", spi_clk, 0);
        check("abort_mosi", spi_mosi, 0);
        check("abort_dout", dout, 8'h00);
        check("abort_done", spi_done, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("abort_stay_idle", spi_idle, 1);
        run_xfer(8'h96, 8'd2, 8'h4D, 1'b0, 1'b0);
        run_xfer(8'($urandom), 8'd1, 8'($urandom), 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
